fetch_instr_queue: RTL and testbench
====================================

// Module: fetch_instr_queue
// PURPOSE
//  Instruction queue directly downstream of the fetch realigner. Accepts up to INSTR_PER_FETCH
//  realigned instructions per cycle with arbitrary per-slot valid bits, compacts them in program
//  order and buffers them in a circular FIFO. Presents one instruction per cycle to decode via a
//  valid/ready handshake and back-pressures fetch when there is no room for a full fetch group.
// PARAMETERS
//  DEPTH            8   queue entries; power of 2, >= 2*INSTR_PER_FETCH
//  INSTR_PER_FETCH  2   input slots per cycle (1..4)
//  VLEN             32  virtual address width
// PORTS
//  clk_i             in   1                    clock
//  rst_ni            in   1                    reset, asynchronous, active-low
//  flush_i           in   1                    synchronous flush (branch mispredict/exception)
//  valid_i           in   INSTR_PER_FETCH      per-slot valid from realigner
//  addr_i            in   INSTR_PER_FETCH*VLEN per-slot instruction address
//  instr_i           in   INSTR_PER_FETCH*32   per-slot instruction, RVC zero-extended in [15:0]
//  ready_o           out  1                    free entries >= INSTR_PER_FETCH
//  fetch_valid_o     out  1                    head entry valid
//  fetch_addr_o      out  VLEN                 head address
//  fetch_instr_o     out  32                   head instruction
//  fetch_is_rvc_o    out  1                    head instr[1:0] != 2'b11
//  fetch_ready_i     in   1                    decode consumes head
//  count_o           out  $clog2(DEPTH+1)      occupied entries
// BEHAVIOUR
//  Reset: rd_ptr=wr_ptr=0, count=0. Outputs: fetch_valid_o=0, count_o=0, ready_o=1;
//   fetch_addr_o/instr_o/is_rvc_o reflect entry 0, which is cleared to 0.
//  push = ready_o & |valid_i & ~flush_i. pop = fetch_valid_o & fetch_ready_i.
//  ready_o = (DEPTH - count) >= INSTR_PER_FETCH, computed from registered count. It does not
//   depend on pop in the same cycle and has no combinational path from any input.
//  Compaction: set slots are written in ascending slot index to wr_ptr, wr_ptr+1, ...
//   n = popcount(valid_i). Gaps are squeezed; e.g. valid_i=2'b10 writes slot1 at wr_ptr.
//  When ready_o=0, input is ignored (not stored). Upstream holds its data until ready_o=1.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Next count = count + n*push - pop.
//   Simultaneous push and pop is legal at any fill level, including count=DEPTH-INSTR_PER_FETCH.
//  Latency: an entry written in cycle N is visible at the head in cycle N+1 at the earliest.
//   There is no bypass, even when the queue is empty.
//  fetch_valid_o = (count != 0) & ~flush_i. Head fields are a combinational read at rd_ptr.
//  Outputs stay stable while fetch_valid_o=1 and fetch_ready_i=0.
//  Flush: next state rd_ptr=wr_ptr=count=0. Any push and pop in the same cycle are discarded.
//   fetch_valid_o=0 during the flush cycle and the following cycle. ready_o=1 the next cycle.
//  Async reset asserted mid-operation: state clears immediately. No entry survives.
//  Assertions: count <= DEPTH always; pop never occurs with count=0; push never overflows.
// TESTING
//  1. Reset, no input -> fetch_valid_o=0, ready_o=1, count_o=0 for 10 cycles.
//  2. valid_i=2'b11 (A@0x100, B@0x102) cycle 0, fetch_ready_i=1 -> A cycle1, B cycle2, count 2,1,0.
//  3. valid_i=2'b10 (C@0x206) -> C at head next cycle, count_o=1, fetch_is_rvc_o per instr[1:0].
//  4. fetch_ready_i=0, push 2 per cycle -> count 2,4,6; ready_o=0 at count 7 or 8; input dropped.
//     Release -> 8 instrs drain in order; ready_o=1 once count<=6 (DEPTH=8).
//  5. count=6, push 2 + pop same cycle -> count 7, order preserved across pointer wrap at 7->0.
//  6. count=5, flush_i=1 with valid_i=2'b11 -> count 0 next cycle, fetch_valid_o=0 two cycles,
//     the flushed-cycle instructions never appear.

Source files
------------

// File: rtl/fetch_instr_queue_if.sv
// fetch_instr_queue_if: realigner-to-queue input slots and queue-to-decode head handshake.
// Signal suffixes are from the queue's point of view.
interface fetch_instr_queue_if #(
    parameter int INSTR_PER_FETCH = 2,
    parameter int VLEN            = 32
);
    logic [INSTR_PER_FETCH-1:0]      valid_i;
    logic [INSTR_PER_FETCH*VLEN-1:0] addr_i;
    logic [INSTR_PER_FETCH*32-1:0]   instr_i;
    logic                            ready_o;
    logic                            fetch_valid_o;
    logic [VLEN-1:0]                 fetch_addr_o;
    logic [31:0]                     fetch_instr_o;
    logic                            fetch_is_rvc_o;
    logic                            fetch_ready_i;

    modport master (
        output valid_i, addr_i, instr_i, fetch_ready_i,
        input  ready_o, fetch_valid_o, fetch_addr_o, fetch_instr_o, fetch_is_rvc_o
    );

    modport slave (
        input  valid_i, addr_i, instr_i, fetch_ready_i,
        output ready_o, fetch_valid_o, fetch_addr_o, fetch_instr_o, fetch_is_rvc_o
    );
endinterface

// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: compacts up to INSTR_PER_FETCH realigned instructions per cycle into a
// circular FIFO and hands them to decode one per cycle.
module fetch_instr_queue #(
    parameter int DEPTH           = 8,
    parameter int INSTR_PER_FETCH = 2,
    parameter int VLEN            = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    fetch_instr_queue_if.slave           fq,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, n;
    logic [CW-1:0]   count_q, count_d;
    logic [VLEN-1:0] addr_q [DEPTH];
    logic [VLEN-1:0] addr_d [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     instr_d [DEPTH];
    logic            push, pop;

    // ready_o only looks at registered count, so fetch never sees a path from decode
    assign fq.ready_o        = count_q <= CW'(DEPTH - INSTR_PER_FETCH);
    assign fq.fetch_valid_o  = (count_q != '0) & ~flush_i;
    assign fq.fetch_addr_o   = addr_q[rd_ptr_q];
    assign fq.fetch_instr_o  = instr_q[rd_ptr_q];
    assign fq.fetch_is_rvc_o = instr_q[rd_ptr_q][1:0] != 2'b11;
    assign push              = fq.ready_o & (|fq.valid_i) & ~flush_i;
    assign pop               = fq.fetch_valid_o & fq.fetch_ready_i;
    assign count_o           = count_q;

    // n is the running popcount: slot i lands at wr_ptr + (set slots below i)
    always_comb begin
        addr_d  = addr_q;
        instr_d = instr_q;
        n       = '0;
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            if (fq.valid_i[i]) begin
                if (push) begin
                    addr_d[wr_ptr_q + n]  = fq.addr_i[i*VLEN +: VLEN];
                    instr_d[wr_ptr_q + n] = fq.instr_i[i*32 +: 32];
                end
                n = n + PW'(1);
            end
        end
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + (push ? n : '0);
        count_d  = flush_i ? '0 : count_q + (push ? CW'(n) : '0) - CW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
        end
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CW'(DEPTH));
    a_no_empty_pop: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> count_q != '0);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> (count_q + CW'(n)) <= CW'(DEPTH));
endmodule

// File: tb/tb_fetch_instr_queue.sv
// tb_fetch_instr_queue: directed vector table, corner sequences and random traffic checked
// against a queue-based reference model.
module tb_fetch_instr_queue;
    localparam int DEPTH = 8;
    localparam int IPF   = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
    } ent_t;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0, i0, a1, i1;
        logic        fr, fl;
        int          e_cnt;
        logic        e_val, e_rdy, e_rvc;
        logic [31:0] e_addr, e_instr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush = 1'b0;
    logic [3:0] count_o;
    int checks = 0;
    int errors = 0;
    ent_t mq[$];
    vec_t tbl[7];

    int s_count;
    logic s_valid, s_ready, s_rvc;
    logic [31:0] s_addr, s_instr;

    fetch_instr_queue_if #(.INSTR_PER_FETCH(IPF), .VLEN(32)) fif ();

    fetch_instr_queue #(.DEPTH(DEPTH), .INSTR_PER_FETCH(IPF), .VLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .flush_i(flush),
        .fq     (fif),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive, compare against the model before the edge, then advance the model.
    task automatic step(input logic [1:0] v, input logic [31:0] a0, i0, a1, i1,
                        input logic fr, fl);
        logic m_ready, m_valid;
        @(negedge clk);
        fif.valid_i       = v;
        fif.addr_i        = {a1, a0};
        fif.instr_i       = {i1, i0};
        fif.fetch_ready_i = fr;
        flush             = fl;
        #2;
        s_count = int'(count_o);
        s_valid = fif.fetch_valid_o;
        s_ready = fif.ready_o;
        s_addr  = fif.fetch_addr_o;
        s_instr = fif.fetch_instr_o;
        s_rvc   = fif.fetch_is_rvc_o;
        m_ready = (DEPTH - mq.size()) >= IPF;
        m_valid = (mq.size() != 0) && !fl;
        chk("model_count", 64'(s_count), 64'(mq.size()));
        chk("model_ready", 64'(s_ready), 64'(m_ready));
        chk("model_valid", 64'(s_valid), 64'(m_valid));
        if (m_valid) begin
            chk("model_addr", 64'(s_addr), 64'(mq[0].a));
            chk("model_instr", 64'(s_instr), 64'(mq[0].i));
            chk("model_rvc", 64'(s_rvc), 64'(mq[0].i[1:0] != 2'b11));
        end
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (m_valid && fr) void'(mq.pop_front());
            if (m_ready && v[0]) mq.push_back('{a0, i0});
            if (m_ready && v[1]) mq.push_back('{a1, i1});
        end
    endtask

    task automatic idle(input logic fr);
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, fr, 1'b0);
    endtask

    initial begin
        fif.valid_i = '0; fif.addr_i = '0; fif.instr_i = '0; fif.fetch_ready_i = 1'b0;
        // inputs applied in a cycle, outputs expected in that same cycle (before the edge)
        tbl[0] = '{2'b00, 32'h0,   32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};
        tbl[1] = '{2'b11, 32'h100, 32'h00a00093, 32'h102, 32'h00004501, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};
        tbl[2] = '{2'b00, 32'h0,   32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b0, 32'h100, 32'h00a00093};
        tbl[3] = '{2'b00, 32'h0,   32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 32'h102, 32'h00004501};
        tbl[4] = '{2'b10, 32'h999, 32'hdeadbeef, 32'h206, 32'h00008082, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};
        tbl[5] = '{2'b00, 32'h0,   32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 32'h206, 32'h00008082};
        tbl[6] = '{2'b00, 32'h0,   32'h0,        32'h0,   32'h0,        1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;

        for (int k = 0; k < 10; k++) begin
            idle(1'b0);
            chk("reset_count", 64'(s_count), 64'd0);
            chk("reset_ready", 64'(s_ready), 64'd1);
            chk("reset_valid", 64'(s_valid), 64'd0);
        end

        for (int k = 0; k < 7; k++) begin
            step(tbl[k].v, tbl[k].a0, tbl[k].i0, tbl[k].a1, tbl[k].i1, tbl[k].fr, tbl[k].fl);
            chk($sformatf("vec%0d_count", k), 64'(s_count), 64'(tbl[k].e_cnt));
            chk($sformatf("vec%0d_valid", k), 64'(s_valid), 64'(tbl[k].e_val));
            chk($sformatf("vec%0d_ready", k), 64'(s_ready), 64'(tbl[k].e_rdy));
            if (tbl[k].e_val) begin
                chk($sformatf("vec%0d_addr", k), 64'(s_addr), 64'(tbl[k].e_addr));
                chk($sformatf("vec%0d_instr", k), 64'(s_instr), 64'(tbl[k].e_instr));
                chk($sformatf("vec%0d_rvc", k), 64'(s_rvc), 64'(tbl[k].e_rvc));
            end
        end

        // fill with decode stalled; the fifth group arrives while full and is dropped
        for (int k = 0; k < 5; k++) begin
            step(2'b11, 32'h1000 + 32'(8*k), 32'h10000003 + 32'(k << 8),
                 32'h1004 + 32'(8*k), 32'h20000003 + 32'(k << 8), 1'b0, 1'b0);
            chk("fill_count", 64'(s_count), 64'((2*k > 8) ? 8 : 2*k));
            chk("fill_ready", 64'(s_ready), 64'(2*k <= 6));
        end
        for (int k = 0; k < 10; k++) idle(1'b1);
        chk("drain_empty", 64'(s_count), 64'd0);

        // push+pop at count 6 from a zeroed pointer: entries 6,7 then wrap to 0
        step(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++)
            step(2'b11, 32'h3000 + 32'(8*k), 32'h30000013 + 32'(k << 8),
                 32'h3004 + 32'(8*k), 32'h30000001 + 32'(k << 8), 1'b0, 1'b0);
        step(2'b11, 32'h3100, 32'h31000013, 32'h3104, 32'h31000002, 1'b1, 1'b0);
        chk("wrap_pre_count", 64'(s_count), 64'd6);
        chk("wrap_pre_ready", 64'(s_ready), 64'd1);
        idle(1'b1);
        chk("wrap_post_count", 64'(s_count), 64'd7);
        chk("wrap_post_ready", 64'(s_ready), 64'd0);
        for (int k = 0; k < 12; k++)
            step(2'b11, 32'h3200 + 32'(8*k), 32'h32000013 + 32'(k << 8),
                 32'h3204 + 32'(8*k), 32'h32000000 + 32'(k << 8), 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) idle(1'b1);

        // flush at count 5 with a full group presented
        idle(1'b0);
        step(2'b01, 32'h4000, 32'h40000013, 32'h0, 32'h0, 1'b0, 1'b0);
        step(2'b11, 32'h4004, 32'h40000113, 32'h4008, 32'h40000213, 1'b0, 1'b0);
        step(2'b11, 32'h400c, 32'h40000313, 32'h4010, 32'h40000413, 1'b0, 1'b0);
        step(2'b11, 32'hbad0, 32'hbad00013, 32'hbad4, 32'hbad40013, 1'b1, 1'b1);
        chk("flush_cycle_count", 64'(s_count), 64'd5);
        chk("flush_cycle_valid", 64'(s_valid), 64'd0);
        idle(1'b1);
        chk("flush_next_count", 64'(s_count), 64'd0);
        chk("flush_next_valid", 64'(s_valid), 64'd0);
        chk("flush_next_ready", 64'(s_ready), 64'd1);
        for (int k = 0; k < 3; k++) idle(1'b1);

        // async reset mid-operation
        step(2'b11, 32'h5000, 32'h50000013, 32'h5004, 32'h50000013, 1'b0, 1'b0);
        step(2'b11, 32'h5008, 32'h50000013, 32'h500c, 32'h50000013, 1'b0, 1'b0);
        @(negedge clk);
        fif.valid_i = '0;
        #1 rst_ni = 1'b0;
        #1;
        chk("async_rst_count", 64'(count_o), 64'd0);
        chk("async_rst_valid", 64'(fif.fetch_valid_o), 64'd0);
        chk("async_rst_ready", 64'(fif.ready_o), 64'd1);
        mq.delete();
        @(negedge clk);
        rst_ni = 1'b1;

        for (int k = 0; k < 400; k++)
            step(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
        for (int k = 0; k < 10; k++) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
